// File: rtl/mem_port_master_pkg.sv
// Shared constants, state encoding and range helper for the memory port master.
// The optional range check is enabled by MEM_PORT_MASTER_BOUNDARY_CHECK_EN.
package mem_port_master_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] MEM_LAST_ADDR = 6'h3D;
    localparam logic [ADDR_W-1:0] ADDR_GPIO_OUT = 6'h3E;
    localparam logic [ADDR_W-1:0] ADDR_GPIO_IN  = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_RD_RESP
    } state_t;

    // True when a burst would run past plain memory into the GPIO words or wrap.
    function automatic logic burst_out_of_range(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] len
    );
        logic [ADDR_W:0] last_addr;
        last_addr = {1'b0, addr} + {1'b0, len};
        return last_addr > {1'b0, MEM_LAST_ADDR};
    endfunction

endpackage

// File: rtl/mem_port_master.sv
// Burst initiator for the single-port main memory (registered read data, 1-cycle latency).
// Define MEM_PORT_MASTER_BOUNDARY_CHECK_EN to reject bursts that would reach 0x3E/0x3F or wrap.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a burst command
// ST_WR      | wdata_ready high, one memory write per accepted word
// ST_RD_WAIT | memory samples mem_addra this cycle
// ST_RD_CAP  | mem_douta valid; capture into rdata
// ST_RD_RESP | rdata_valid high until the consumer takes the word
module mem_port_master
    import mem_port_master_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              cmd_err,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addra_d;
    logic [DATA_W-1:0] mem_dina_d, rdata_d;
    logic              mem_wea_d, rdata_valid_d, done_d, cmd_err_d;
    logic              cmd_reject;

`ifdef MEM_PORT_MASTER_BOUNDARY_CHECK_EN
    assign cmd_reject = burst_out_of_range(cmd_addr, cmd_len);
`else
    assign cmd_reject = 1'b0;
`endif

    assign cmd_ready   = (state_q == ST_IDLE);
    assign wdata_ready = (state_q == ST_WR);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        mem_wea_d     = 1'b0;
        mem_addra_d   = mem_addra;
        mem_dina_d    = mem_dina;
        rdata_d       = rdata;
        rdata_valid_d = rdata_valid;
        done_d        = 1'b0;
        cmd_err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_reject) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        addr_d = cmd_addr;
                        cnt_d  = cmd_len;
                        if (cmd_write) begin
                            state_d = ST_WR;
                        end else begin
                            state_d     = ST_RD_WAIT;
                            mem_addra_d = cmd_addr;
                        end
                    end
                end
            end
            ST_WR: begin
                if (wdata_valid) begin
                    mem_wea_d   = 1'b1;
                    mem_addra_d = addr_q;
                    mem_dina_d  = wdata;
                    addr_d      = addr_q + ADDR_W'(1);
                    cnt_d       = cnt_q - ADDR_W'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                rdata_d       = mem_douta;
                rdata_valid_d = 1'b1;
                state_d       = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (rdata_ready) begin
                    rdata_valid_d = 1'b0;
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // Read bursts step the memory address register directly.
                        mem_addra_d = mem_addra + ADDR_W'(1);
                        cnt_d       = cnt_q - ADDR_W'(1);
                        state_d     = ST_RD_WAIT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            mem_wea     <= 1'b0;
            mem_addra   <= '0;
            mem_dina    <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            mem_wea     <= mem_wea_d;
            mem_addra   <= mem_addra_d;
            mem_dina    <= mem_dina_d;
            rdata       <= rdata_d;
            rdata_valid <= rdata_valid_d;
            done        <= done_d;
            cmd_err     <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_master.sv
// Self-checking bench for mem_port_master: scoreboard of expected writes/reads plus directed checks.
module tb_mem_port_master;
    import mem_port_master_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_addr, cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid, rdata_ready;
    logic [31:0] rdata;
    logic        done, cmd_err;
    logic        mem_wea;
    logic [5:0]  mem_addra;
    logic [31:0] mem_dina, mem_douta;

    mem_port_master #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .done(done), .cmd_err(cmd_err),
        .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_douta(mem_douta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with registered read port.
    logic [31:0] ram [64];
    always @(posedge clk) begin
        if (mem_wea) ram[mem_addra] <= mem_dina;
        mem_douta <= ram[mem_addra];
    end

    typedef struct { logic [5:0] a; logic [31:0] d; bit last; } wr_t;
    typedef struct { logic [31:0] d; bit last; } rd_t;

    wr_t         wq[$];
    rd_t         rq[$];
    logic [31:0] ref_mem [64];
    logic [31:0] wbuf[$];
    logic [5:0]  wlog_a[$];
    logic [31:0] wlog_d[$];
    int          wea_cnt = 0, rd_hs = 0, done_cnt = 0;
    int          tests = 0, fails = 0;
    bit          chk_en = 0, rd_last_pend = 0, prev_stall = 0;
    logic [31:0] prev_rdata;
    bit          last_hs_done;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Per-cycle compare against the scoreboard.
    always @(negedge clk) begin : compare
        bit  exp_done;
        wr_t w;
        rd_t r;
        if (chk_en) begin
            exp_done     = rd_last_pend;
            rd_last_pend = 0;
            if (mem_wea) begin
                wea_cnt++;
                wlog_a.push_back(mem_addra);
                wlog_d.push_back(mem_dina);
                if (wq.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", 32'(mem_addra), 32'(w.a));
                    chk("wr_data", mem_dina, w.d);
                    exp_done = w.last;
                end
            end
            chk("done", 32'(done), 32'(exp_done));
            if (rdata_valid && prev_stall) chk("rdata_stable", rdata, prev_rdata);
            if (rdata_valid && rdata_ready) begin
                if (rq.size() == 0) begin
                    fail_now("unexpected_read_word");
                end else begin
                    r = rq.pop_front();
                    chk("rd_data", rdata, r.d);
                    rd_last_pend = r.last;
                end
                rd_hs++;
            end
            prev_stall = rdata_valid && !rdata_ready;
            prev_rdata = rdata;
            if (done) done_cnt++;
`ifndef MEM_PORT_MASTER_BOUNDARY_CHECK_EN
            chk("cmd_err_idle", 32'(cmd_err), 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_write(logic [5:0] a, logic [5:0] l);
        logic [5:0] addr;
        for (int i = 0; i <= int'(l); i++) begin
            addr = a + 6'(i);
            ref_mem[addr] = wbuf[i];
            wq.push_back('{a: addr, d: wbuf[i], last: (i == int'(l))});
        end
    endtask

    task automatic push_read(logic [5:0] a, logic [5:0] l);
        logic [5:0] addr;
        for (int i = 0; i <= int'(l); i++) begin
            addr = a + 6'(i);
            rq.push_back('{d: ref_mem[addr], last: (i == int'(l))});
        end
    endtask

    task automatic issue_cmd(bit wr, logic [5:0] a, logic [5:0] l);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                last_hs_done = done;
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                return;
            end
        end
        fail_now("cmd_handshake_timeout");
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(logic [31:0] d, int gap);
        repeat (gap) tick();
        wdata       = d;
        wdata_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wdata_ready) begin
                @(posedge clk);
                #1;
                wdata_valid = 1'b0;
                return;
            end
        end
        fail_now("wdata_handshake_timeout");
        wdata_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                tick();
                return;
            end
        end
        fail_now("idle_timeout");
    endtask

    task automatic wait_rvalid(output bit ok);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rdata_valid) begin
                ok = 1;
                return;
            end
        end
        fail_now("rdata_valid_timeout");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base, w0, d0, h0, k;
        bit ok;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_len     = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        rdata_ready = 1'b1;

        #21;
        chk("rst_cmd_ready",   32'(cmd_ready),   32'd1);
        chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        chk("rst_mem_wea",     32'(mem_wea),     32'd0);
        chk("rst_mem_addra",   32'(mem_addra),   32'd0);
        chk("rst_mem_dina",    mem_dina,         32'd0);
        chk("rst_rdata",       rdata,            32'd0);
        chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("rst_done",        32'(done),        32'd0);
        chk("rst_cmd_err",     32'(cmd_err),     32'd0);
        #1 rst_n = 1'b1;
        chk_en = 1;
        tick();

        // Single-word write.
        base = wlog_a.size(); w0 = wea_cnt; d0 = done_cnt;
        wbuf = '{32'hDEADBEEF};
        push_write(6'h05, 6'd0);
        issue_cmd(1'b1, 6'h05, 6'd0);
        send_word(32'hDEADBEEF, 0);
        wait_idle();
        chk("single_wea_cycles", 32'(wea_cnt - w0), 32'd1);
        chk("single_done_pulses", 32'(done_cnt - d0), 32'd1);
        if (wlog_a.size() > base) begin
            chk("single_addr", 32'(wlog_a[base]), 32'h05);
            chk("single_data", wlog_d[base], 32'hDEADBEEF);
        end else fail_now("single_no_write_seen");

        // Write burst with 2-cycle gaps between words.
        base = wlog_a.size(); w0 = wea_cnt;
        wbuf = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        push_write(6'h10, 6'd3);
        issue_cmd(1'b1, 6'h10, 6'd3);
        for (int i = 0; i < 4; i++) send_word(wbuf[i], 2);
        wait_idle();
        chk("gap_wea_cycles", 32'(wea_cnt - w0), 32'd4);
        if (wlog_a.size() >= base + 4) begin
            chk("gap_addr0", 32'(wlog_a[base]),   32'h10);
            chk("gap_addr3", 32'(wlog_a[base+3]), 32'h13);
            chk("gap_data2", wlog_d[base+2],      32'h33333333);
        end else fail_now("gap_writes_missing");

        // Preload 0x10..0x12, then read it back with a stall on word 1.
        wbuf = '{32'hA0, 32'hA1, 32'hA2};
        push_write(6'h10, 6'd2);
        issue_cmd(1'b1, 6'h10, 6'd2);
        for (int i = 0; i < 3; i++) send_word(wbuf[i], 0);
        wait_idle();

        h0 = rd_hs; d0 = done_cnt; w0 = wea_cnt;
        push_read(6'h10, 6'd2);
        issue_cmd(1'b0, 6'h10, 6'd2);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rdata_valid) begin
                k = i;
                break;
            end
        end
        chk("rd_first_latency", 32'(k), 32'd3);
        chk("rd_word0", rdata, 32'hA0);
        tick();
        rdata_ready = 1'b0;
        wait_rvalid(ok);
        if (ok) begin
            chk("rd_stall_word1", rdata, 32'hA1);
            repeat (5) begin
                @(negedge clk);
                chk("rd_stall_valid", 32'(rdata_valid), 32'd1);
                chk("rd_stall_hold", rdata, 32'hA1);
            end
        end
        tick();
        rdata_ready = 1'b1;
        wait_idle();
        chk("rd_words_returned", 32'(rd_hs - h0), 32'd3);
        chk("rd_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("rd_no_writes", 32'(wea_cnt - w0), 32'd0);

        // Burst starting at 0x3C, running into the GPIO words.
`ifndef MEM_PORT_MASTER_BOUNDARY_CHECK_EN
        base = wlog_a.size();
        wbuf = '{32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3};
        push_write(6'h3C, 6'd3);
        issue_cmd(1'b1, 6'h3C, 6'd3);
        for (int i = 0; i < 4; i++) send_word(wbuf[i], 0);
        wait_idle();
        if (wlog_a.size() >= base + 4) begin
            chk("wrap_addr0", 32'(wlog_a[base]),   32'h3C);
            chk("wrap_addr1", 32'(wlog_a[base+1]), 32'h3D);
            chk("wrap_addr2", 32'(wlog_a[base+2]), 32'h3E);
            chk("wrap_addr3", 32'(wlog_a[base+3]), 32'h3F);
        end else fail_now("wrap_writes_missing");
        chk("wrap_gpio_out", ram[ADDR_GPIO_OUT], 32'hC2C2C2C2);
`else
        w0 = wea_cnt;
        issue_cmd(1'b1, 6'h3C, 6'd3);
        @(negedge clk);
        chk("reject_cmd_err", 32'(cmd_err), 32'd1);
        chk("reject_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        chk("reject_err_pulse_len", 32'(cmd_err), 32'd0);
        repeat (3) tick();
        chk("reject_no_writes", 32'(wea_cnt - w0), 32'd0);
`endif

        // Reset while word 1 of a read burst is being presented.
        push_read(6'h10, 6'd2);
        rdata_ready = 1'b1;
        issue_cmd(1'b0, 6'h10, 6'd2);
        wait_rvalid(ok);
        tick();
        rdata_ready = 1'b0;
        wait_rvalid(ok);
        chk("rst_mid_word1", rdata, 32'hA1);
        #1 rst_n = 1'b0;
        chk_en = 0;
        #1;
        chk("rst_mid_wea",    32'(mem_wea),     32'd0);
        chk("rst_mid_rvalid", 32'(rdata_valid), 32'd0);
        chk("rst_mid_done",   32'(done),        32'd0);
        wq.delete();
        rq.delete();
        rd_last_pend = 0;
        prev_stall   = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_mid_no_done",   32'(done),      32'd0);
        chk_en = 1;
        tick();
        rdata_ready = 1'b1;

        // Write 0x07, then read it back with the read accepted in the done cycle.
        wbuf = '{32'h12345678};
        push_write(6'h07, 6'd0);
        issue_cmd(1'b1, 6'h07, 6'd0);
        send_word(32'h12345678, 0);
        push_read(6'h07, 6'd0);
        issue_cmd(1'b0, 6'h07, 6'd0);
        chk("b2b_accept_in_done", 32'(last_hs_done), 32'd1);
        wait_rvalid(ok);
        if (ok) chk("b2b_readback", rdata, 32'h12345678);
        wait_idle();

        repeat (3) tick();
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
